// File: rtl/det_pkg.sv
// Shared state coding and default timing for the detector / alarm blocks.
package det_pkg;

  // 2-bit Gray-style coding shared with the sequence detector; 2'b10 is unused.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ALARM = 2'b01,
    COOL  = 2'b11
  } state_t;

  localparam int DEF_HOLD_CYC = 16;
  localparam int DEF_COOL_CYC = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Registers the input level and flags the cycle where it goes 0 -> 1.
module edge_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-cycle copy of the level; cleared on reset so a level already
  // high after reset release reads as a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/det_event_alarm.sv
// Detection event strobe, saturating event counter and alarm FSM with
// hold time, acknowledge and cooldown.
module det_event_alarm
  import det_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int COOL_CYC = DEF_COOL_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             clr,
  input  logic             ack,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             cnt_sat,
  output logic             alarm,
  output logic             busy
);

  localparam int TW = $clog2(max_int(HOLD_CYC, COOL_CYC)) + 1;
  localparam logic [TW-1:0]    HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]    COOL_LD = TW'(COOL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic          rise;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  edge_rise_det u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (det_in),
    .rise (rise)
  );

  // Event strobe and saturating counter; clr wins over the count but a
  // coincident rise is still kept as the first event after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_pulse <= 1'b0;
      evt_cnt   <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      evt_pulse <= rise;
      if (clr) begin
        evt_cnt <= rise ? CNT_W'(1) : '0;
        cnt_sat <= 1'b0;
      end else if (rise && (evt_cnt != CNT_MAX)) begin
        evt_cnt <= evt_cnt + 1'b1;
        if (evt_cnt == CNT_MAX - 1'b1) cnt_sat <= 1'b1;
      end
    end
  end

  // Next state / timer: a rise in ALARM retriggers ahead of ack and timeout;
  // COOL ignores both rise and ack and simply runs out.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ALARM;
          timer_d = HOLD_LD;
        end
      end
      ALARM: begin
        if (rise) begin
          timer_d = HOLD_LD;
        end else if (ack || (timer_q == '0)) begin
          state_d = COOL;
          timer_d = COOL_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      COOL: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign alarm = (state_q == ALARM);
  assign busy  = (state_q != IDLE);

endmodule
